// File: rtl/upsample_row_stream.sv
// Streaming 2x horizontal bilinear upsampler for one feature-map row.
// Each accepted pixel is paired with its left neighbour. Every pair produces two
// interpolated samples with 3/4-1/4 shift-add weights. The first and last pixels
// of the row are replicated, so an N-pixel row becomes a 2N-pixel row.
module upsample_row_stream #(
    parameter int unsigned length  = 12,
    parameter int unsigned frac    = 8,
    parameter int unsigned row_len = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [length-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [length-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int unsigned      cnt_w     = $clog2(row_len + 1);
    localparam logic [cnt_w-1:0] row_len_c = cnt_w'(row_len);

    // The interpolation needs a left neighbour, and frac must describe bits inside the word.
    if (row_len < 2) begin : g_bad_row_len
        $error("upsample_row_stream: row_len must be >= 2");
    end
    if (frac > length) begin : g_bad_frac
        $error("upsample_row_stream: frac must not exceed length");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StEmitQ,
        StLast
    } state_t;

    state_t              state_q, state_d;
    logic [length-1:0]   prev_q, prev_d;
    logic [length-1:0]   cur_q, cur_d;
    logic [cnt_w-1:0]    cnt_q, cnt_d;
    logic [length-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;

    logic                slot_free;
    logic                s_fire;
    logic                m_fire;
    logic                load;
    logic                load_last;

    // Weighted toward a: 3/4 a + 1/4 b. Each term truncates on its own.
    function automatic logic [length-1:0] interp_p(input logic [length-1:0] a,
                                                   input logic [length-1:0] b);
        return (a >> 1) + (a >> 2) + (b >> 2);
    endfunction

    // Weighted toward b: 1/4 a + 3/4 b.
    function automatic logic [length-1:0] interp_q(input logic [length-1:0] a,
                                                   input logic [length-1:0] b);
        return (b >> 2) + (b >> 1) + (a >> 2);
    endfunction

    assign slot_free = !m_valid_q || m_ready;
    assign m_fire    = m_valid_q && m_ready;
    assign s_fire    = s_valid && s_ready;

    // Input handshake: only the pixel-collecting states accept input, and never in reset.
    always_comb begin
        s_ready = 1'b0;
        if (rst_n && (state_q == StIdle || state_q == StWait)) begin
            s_ready = slot_free;
        end
    end

    // Next-state logic for the FSM, the pixel pair registers and the output register.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        load      = 1'b0;
        load_last = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s_fire) begin
                    prev_d   = s_data;
                    m_data_d = s_data;
                    cnt_d    = cnt_w'(1);
                    load     = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (s_fire) begin
                    cur_d    = s_data;
                    m_data_d = interp_p(prev_q, s_data);
                    cnt_d    = cnt_q + 1'b1;
                    load     = 1'b1;
                    state_d  = StEmitQ;
                end
            end
            StEmitQ: begin
                if (slot_free) begin
                    m_data_d = interp_q(prev_q, cur_q);
                    prev_d   = cur_q;
                    load     = 1'b1;
                    state_d  = (cnt_q == row_len_c) ? StLast : StWait;
                end
            end
            StLast: begin
                // Right edge: replicate the final input pixel.
                if (slot_free) begin
                    m_data_d  = prev_q;
                    load      = 1'b1;
                    load_last = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            m_valid_d = 1'b1;
            m_last_d  = load_last;
        end else if (m_fire) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prev_q    <= '0;
            cur_q     <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_upsample_row_stream.sv
// Bench for upsample_row_stream: two instances (row_len 4 and row_len 2) driven
// one at a time, checked against a row-level reference model and a scoreboard.
module tb_upsample_row_stream;

    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] a_sd, a_md, b_sd, b_md;
    logic a_sv, a_sr, a_mv, a_mr, a_ml;
    logic b_sv, b_sr, b_mv, b_mr, b_ml;

    upsample_row_stream #(.length(W), .frac(8), .row_len(4)) u_a (
        .clk(clk), .rst_n(rst_n), .s_data(a_sd), .s_valid(a_sv), .s_ready(a_sr),
        .m_data(a_md), .m_valid(a_mv), .m_ready(a_mr), .m_last(a_ml)
    );

    upsample_row_stream #(.length(W), .frac(8), .row_len(2)) u_b (
        .clk(clk), .rst_n(rst_n), .s_data(b_sd), .s_valid(b_sv), .s_ready(b_sr),
        .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr), .m_last(b_ml)
    );

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    int last_cnt = 0;

    logic [W-1:0] row_q[$];
    logic [W-1:0] in_q[$];
    logic [W-1:0] exp_d[$];
    logic         exp_l[$];

    bit           stall_prev;
    logic [W-1:0] held_d;
    logic         held_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: floor(3a/4)-style weights computed as independent truncated quarters.
    function automatic logic [W-1:0] ref_p(input int a, input int b);
        int v;
        v = a / 2 + a / 4 + b / 4;
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_q(input int a, input int b);
        int v;
        v = b / 4 + b / 2 + a / 4;
        return v[W-1:0];
    endfunction

    // Queue row_q as one input row and its expected 2N-sample output row.
    task automatic add_row();
        int n;
        n = row_q.size();
        for (int i = 0; i < n; i++) begin
            in_q.push_back(row_q[i]);
            if (i == 0) begin
                exp_d.push_back(row_q[0]);
                exp_l.push_back(1'b0);
            end else begin
                exp_d.push_back(ref_p(int'(row_q[i-1]), int'(row_q[i])));
                exp_l.push_back(1'b0);
                exp_d.push_back(ref_q(int'(row_q[i-1]), int'(row_q[i])));
                exp_l.push_back(1'b0);
            end
        end
        exp_d.push_back(row_q[n-1]);
        exp_l.push_back(1'b1);
        row_q.delete();
    endtask

    task automatic drive(input bit sel, input bit sv, input logic [W-1:0] d, input bit mr);
        if (sel) begin
            b_sv = sv; b_sd = d; b_mr = mr;
        end else begin
            a_sv = sv; a_sd = d; a_mr = mr;
        end
    endtask

    task automatic sample(input bit sel, output logic sr, output logic mv, output logic ml,
                          output logic [W-1:0] md);
        if (sel) begin
            sr = b_sr; mv = b_mv; ml = b_ml; md = b_md;
        end else begin
            sr = a_sr; mv = a_mv; ml = a_ml; md = a_md;
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic tick(input bit sel, input bit want_v, input bit mr, output bit mv_o);
        bit           sv;
        logic [W-1:0] d;
        logic         sr, mv, ml;
        logic [W-1:0] md;
        sv = want_v && (in_q.size() > 0);
        d  = sv ? in_q[0] : '0;
        drive(sel, sv, d, mr);
        #1;
        sample(sel, sr, mv, ml, md);
        if (stall_prev) begin
            chk("hold_valid", 32'(mv), 32'd1);
            chk("hold_data", 32'(md), 32'(held_d));
            chk("hold_last", 32'(ml), 32'(held_l));
        end
        if (mv && !mr) chk("sready_stall", 32'(sr), 32'd0);
        if (sv && sr) void'(in_q.pop_front());
        if (mv && mr) begin
            chk("out_expected", 32'(exp_d.size() > 0), 32'd1);
            if (exp_d.size() > 0) begin
                chk("data", 32'(md), 32'(exp_d.pop_front()));
                chk("last", 32'(ml), 32'(exp_l.pop_front()));
            end
            out_cnt++;
            if (ml) last_cnt++;
        end
        stall_prev = mv && !mr;
        held_d = md;
        held_l = ml;
        mv_o = mv;
        @(negedge clk);
    endtask

    // vmode: 0 always valid, 1 toggle, 2 random. rmode: 0 always ready, 1 stall after
    // first valid for stall_n cycles, 2 random.
    task automatic run(input bit sel, input int vmode, input int rmode, input int stall_n,
                       input int budget, output int ticks, output int gaps);
        bit   want_v, mr, mv, started;
        int   stalled;
        logic sr0, mv0, ml0;
        logic [W-1:0] md0;
        stall_prev = 0;
        ticks = 0; gaps = 0; started = 0; stalled = 0;
        while (exp_d.size() > 0 && ticks < budget) begin
            case (vmode)
                0: want_v = 1'b1;
                1: want_v = (ticks % 2) == 0;
                default: want_v = ($urandom_range(0, 3) != 0);
            endcase
            sample(sel, sr0, mv0, ml0, md0);
            case (rmode)
                0: mr = 1'b1;
                1: begin
                    if (mv0 && stalled < stall_n) begin
                        mr = 1'b0;
                        stalled++;
                    end else begin
                        mr = 1'b1;
                    end
                end
                default: mr = ($urandom_range(0, 2) != 0);
            endcase
            tick(sel, want_v, mr, mv);
            if (mv) started = 1;
            else if (started && exp_d.size() > 0) gaps++;
            ticks++;
        end
        chk("drained", 32'(exp_d.size()), 32'd0);
        chk("inputs_consumed", 32'(in_q.size()), 32'd0);
        drive(sel, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int   t, g;
        bit   mv;
        int   n;

        // Reset with s_valid high: s_ready must stay low, outputs cleared.
        drive(0, 1'b1, 12'h5A5, 1'b1);
        drive(1, 1'b1, 12'h5A5, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_sready", 32'(a_sr), 32'd0);
        chk("rst_a_mvalid", 32'(a_mv), 32'd0);
        chk("rst_a_mdata", 32'(a_md), 32'd0);
        chk("rst_a_mlast", 32'(a_ml), 32'd0);
        chk("rst_b_sready", 32'(b_sr), 32'd0);
        chk("rst_b_mvalid", 32'(b_mv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, '0, 1'b1);
        drive(1, 1'b0, '0, 1'b1);
        @(negedge clk);

        // Case 1: 100,200,300,400 at full rate -> 8 contiguous outputs.
        row_q = '{12'h100, 12'h200, 12'h300, 12'h400};
        add_row();
        last_cnt = 0;
        run(0, 0, 0, 0, 200, t, g);
        chk("c1_cycles", 32'(t), 32'd9);
        chk("c1_gaps", 32'(g), 32'd0);
        chk("c1_lasts", 32'(last_cnt), 32'd1);

        // Case 2: truncation and maximum values on the row_len=2 instance.
        row_q = '{12'h003, 12'h001};
        add_row();
        run(1, 0, 0, 0, 200, t, g);
        chk("c2_trunc_cycles", 32'(t), 32'd5);
        row_q = '{12'hFFF, 12'hFFF};
        add_row();
        run(1, 0, 0, 0, 200, t, g);
        chk("c2_max_cycles", 32'(t), 32'd5);

        // Case 3: five stall cycles after the first valid output.
        row_q = '{12'h100, 12'h200, 12'h300, 12'h400};
        add_row();
        run(0, 0, 1, 5, 200, t, g);
        chk("c3_cycles", 32'(t), 32'd14);
        chk("c3_gaps", 32'(g), 32'd0);

        // Case 4: input bubbles on every other cycle.
        row_q = '{12'h100, 12'h200, 12'h300, 12'h400};
        add_row();
        run(0, 1, 0, 0, 200, t, g);

        // Case 6: three back-to-back rows at full rate.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) row_q.push_back(W'($urandom));
            add_row();
        end
        last_cnt = 0;
        run(0, 0, 0, 0, 400, t, g);
        chk("c6_cycles", 32'(t), 32'd25);
        chk("c6_gaps", 32'(g), 32'd0);
        chk("c6_lasts", 32'(last_cnt), 32'd3);

        // Randomised rows with random valid/ready on both instances.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) row_q.push_back(W'($urandom));
            add_row();
        end
        run(0, 2, 2, 0, 2000, t, g);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 2; i++) row_q.push_back(W'($urandom));
            add_row();
        end
        run(1, 2, 2, 0, 2000, t, g);

        // Case 5: reset after three outputs of a row, then a fresh row.
        row_q = '{12'h123, 12'h456};
        add_row();
        out_cnt = 0;
        stall_prev = 0;
        n = 0;
        while (out_cnt < 3 && n < 50) begin
            tick(1, 1'b1, 1'b1, mv);
            n++;
        end
        chk("c5_three_out", 32'(out_cnt), 32'd3);
        rst_n = 1'b0;
        drive(1, 1'b1, 12'h777, 1'b1);
        #1;
        chk("c5_rst_sready", 32'(b_sr), 32'd0);
        @(posedge clk);
        #1;
        chk("c5_rst_mvalid", 32'(b_mv), 32'd0);
        chk("c5_rst_mlast", 32'(b_ml), 32'd0);
        chk("c5_rst_mdata", 32'(b_md), 32'd0);
        in_q.delete();
        exp_d.delete();
        exp_l.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1'b0, '0, 1'b1);
        @(negedge clk);
        row_q = '{12'h010, 12'h020};
        add_row();
        run(1, 0, 0, 0, 200, t, g);
        chk("c5_new_row_cycles", 32'(t), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
